// File: rtl/dap_arbiter.sv
// dap_arbiter -- two-requester arbiter/sequencer for the debug capture port.
//
// Shares one DW-bit capture register (DCP) between debug bus 1 and debug
// bus 2. Request/grant handshake, round-robin priority between tenures,
// per-tenure burst limit, optional inactivity timeout.
//
// Optional feature macro: DAP_TIMEOUT_EN
//   defined   : idle counter built; an owner idle for TIMEOUT cycles is
//               revoked and tmo pulses for one cycle.
//   undefined : tenures end only on req drop or burst limit; tmo = 0.
//
// Ports:
//   clk            sole clock, rising edge
//   MRST           asynchronous active-high reset
//   req1/req2      requester wants the port (held for the tenure)
//   v1/v2          word valid on DB1/DB2
//   DB1/DB2        requester data
//   dcp_rdy        consumer takes DCP this cycle
//   rdy1/rdy2      combinational: requester word taken this cycle if v high
//   gnt1/gnt2      registered grant, one-hot or zero
//   DCP/dcp_vld    captured word and its unconsumed flag
//   SEL            00 idle, 11 bus 1, 10 bus 2, 01 release
//   tmo            one-cycle pulse on timeout revocation
module dap_arbiter #(
  parameter int DW        = 32,
  parameter int MAX_BURST = 4,
  parameter int TIMEOUT   = 15
) (
  input  logic          clk,
  input  logic          MRST,
  input  logic          req1,
  input  logic          req2,
  input  logic          v1,
  input  logic          v2,
  input  logic [DW-1:0] DB1,
  input  logic [DW-1:0] DB2,
  input  logic          dcp_rdy,
  output logic          rdy1,
  output logic          rdy2,
  output logic          gnt1,
  output logic          gnt2,
  output logic [DW-1:0] DCP,
  output logic          dcp_vld,
  output logic [1:0]    SEL,
  output logic          tmo
);

  typedef enum logic [1:0] {S_IDLE, S_OWN1, S_OWN2, S_REL} state_t;

  localparam logic [1:0] SEL_IDLE = 2'b00;
  localparam logic [1:0] SEL_BUS1 = 2'b11;
  localparam logic [1:0] SEL_BUS2 = 2'b10;
  localparam logic [1:0] SEL_REL  = 2'b01;
  localparam logic [3:0] BURST_LAST = 4'(MAX_BURST - 1);

  if (MAX_BURST < 1 || MAX_BURST > 15) begin : g_bad_burst
    $error("dap_arbiter: MAX_BURST must be 1..15");
  end
  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_bad_timeout
    $error("dap_arbiter: TIMEOUT must be 1..255");
  end

  state_t        state;
  logic          ptr;        // 0: bus 1 wins a tie, 1: bus 2 wins
  logic [3:0]    burst;      // captures made in the current tenure
  logic          slot_free;
  logic          cap1, cap2, cap;
  logic          own, own_req;
  logic          last_word, tmo_hit, tenure_end;
  logic [DW-1:0] cap_data;

  // DCP can take a word when empty or being drained this same cycle.
  assign slot_free = !dcp_vld || dcp_rdy;
  assign rdy1      = gnt1 && req1 && slot_free;
  assign rdy2      = gnt2 && req2 && slot_free;
  assign cap1      = v1 && rdy1;
  assign cap2      = v2 && rdy2;
  assign cap       = cap1 || cap2;
  assign cap_data  = cap1 ? DB1 : DB2;

  assign own       = gnt1 || gnt2;
  assign own_req   = gnt1 ? req1 : req2;
  assign last_word = cap && (burst == BURST_LAST);

`ifdef DAP_TIMEOUT_EN
  localparam logic [7:0] IDLE_LAST = 8'(TIMEOUT - 1);
  logic [7:0] idle_cnt;      // owned cycles since the last capture
  // Counter reaches TIMEOUT on this edge when it is one short now.
  assign tmo_hit = own && !cap && (idle_cnt == IDLE_LAST);
`else
  assign tmo_hit = 1'b0;
  assign tmo     = 1'b0;
`endif

  assign tenure_end = own && (!own_req || last_word || tmo_hit);

  // Arbitration FSM; gnt/SEL/tmo are registered alongside the state.
  always_ff @(posedge clk or posedge MRST) begin
    if (MRST) begin
      state <= S_IDLE;
      ptr   <= 1'b0;
      burst <= '0;
      gnt1  <= 1'b0;
      gnt2  <= 1'b0;
      SEL   <= SEL_IDLE;
`ifdef DAP_TIMEOUT_EN
      idle_cnt <= '0;
      tmo      <= 1'b0;
`endif
    end else begin
`ifdef DAP_TIMEOUT_EN
      tmo <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (req1 && (!req2 || !ptr)) begin
            state <= S_OWN1;
            gnt1  <= 1'b1;
            SEL   <= SEL_BUS1;
          end else if (req2) begin
            state <= S_OWN2;
            gnt2  <= 1'b1;
            SEL   <= SEL_BUS2;
          end
        end
        S_OWN1, S_OWN2: begin
          if (tenure_end) begin
            state <= S_REL;
            gnt1  <= 1'b0;
            gnt2  <= 1'b0;
            SEL   <= SEL_REL;
            // Hand priority to the requester that did not just own.
            ptr   <= (state == S_OWN1);
            burst <= '0;
`ifdef DAP_TIMEOUT_EN
            idle_cnt <= '0;
            // A req drop on the same edge is an ordinary release.
            tmo      <= tmo_hit && own_req;
`endif
          end else begin
            if (cap) burst <= burst + 4'd1;
`ifdef DAP_TIMEOUT_EN
            idle_cnt <= cap ? '0 : idle_cnt + 8'd1;
`endif
          end
        end
        default: begin
          state <= S_IDLE;
          SEL   <= SEL_IDLE;
        end
      endcase
    end
  end

  // Capture register. A held word survives tenure changes until drained.
  always_ff @(posedge clk or posedge MRST) begin
    if (MRST) begin
      DCP     <= '0;
      dcp_vld <= 1'b0;
    end else if (cap) begin
      DCP     <= cap_data;
      dcp_vld <= 1'b1;
    end else if (dcp_rdy) begin
      dcp_vld <= 1'b0;
    end
  end

endmodule

// File: tb/tb_dap_arbiter.sv
module tb_dap_arbiter;

  localparam int TMO = 3;
  localparam int MB  = 4;

  logic        clk = 1'b0;
  logic        MRST;
  logic        req1, req2, v1, v2, dcp_rdy;
  logic [31:0] DB1, DB2;
  logic        rdy1, rdy2, gnt1, gnt2, dcp_vld, tmo;
  logic [31:0] DCP;
  logic [1:0]  SEL;

  dap_arbiter #(.DW(32), .MAX_BURST(MB), .TIMEOUT(TMO)) dut (
    .clk(clk), .MRST(MRST), .req1(req1), .req2(req2), .v1(v1), .v2(v2),
    .DB1(DB1), .DB2(DB2), .dcp_rdy(dcp_rdy), .rdy1(rdy1), .rdy2(rdy2),
    .gnt1(gnt1), .gnt2(gnt2), .DCP(DCP), .dcp_vld(dcp_vld), .SEL(SEL),
    .tmo(tmo)
  );

  always #5 clk = ~clk;

  int nvec = 0;
  int nerr = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    nvec++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h, expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- behavioural reference model ----------------
  // phase: 0 waiting for a request, 1 someone owns the port, 2 release gap
  int          m_phase, m_owner, m_words, m_idle;
  bit          m_ptr, m_vld, m_tmo;
  logic [31:0] m_dcp;

  function automatic void model_reset();
    m_phase = 0; m_owner = 0; m_words = 0; m_idle = 0;
    m_ptr = 0; m_vld = 0; m_tmo = 0; m_dcp = '0;
  endfunction

  function automatic bit m_req(input int i);
    return (i == 1) ? req1 : (i == 2) ? req2 : 1'b0;
  endfunction

  function automatic bit m_rdy(input int i);
    return m_phase == 1 && m_owner == i && m_req(i) && (!m_vld || dcp_rdy);
  endfunction

  function automatic void model_edge();
    bit cap, done;
    cap = 0;
    if (m_phase == 1) cap = ((m_owner == 1) ? v1 : v2) && m_rdy(m_owner);
    if (cap) begin
      m_dcp = (m_owner == 1) ? DB1 : DB2;
      m_vld = 1;
    end else if (dcp_rdy) m_vld = 0;
    m_tmo = 0;
    case (m_phase)
      0: if (req1 || req2) begin
        m_owner = (req1 && req2) ? (m_ptr ? 2 : 1) : (req1 ? 1 : 2);
        m_phase = 1; m_words = 0; m_idle = 0;
      end
      1: begin
        done = !m_req(m_owner);
        if (!done && cap) begin
          m_words++;
          m_idle = 0;
          done = (m_words == MB);
        end else if (!done) begin
          m_idle++;
`ifdef DAP_TIMEOUT_EN
          if (m_idle == TMO) begin done = 1; m_tmo = 1; end
`endif
        end
        if (done) begin
          m_ptr = (m_owner == 1);
          m_owner = 0;
          m_phase = 2;
        end
      end
      default: m_phase = 0;
    endcase
  endfunction

  function automatic logic [1:0] m_sel();
    if (m_phase == 1) return (m_owner == 1) ? 2'b11 : 2'b10;
    if (m_phase == 2) return 2'b01;
    return 2'b00;
  endfunction

  // ---------------- drive one cycle, check against the model ----------------
  logic seen_rdy1, seen_rdy2;

  task automatic step(input logic r1, input logic r2, input logic a1, input logic a2,
                      input logic [31:0] d1, input logic [31:0] d2, input logic rd);
    req1 = r1; req2 = r2; v1 = a1; v2 = a2; DB1 = d1; DB2 = d2; dcp_rdy = rd;
    #1;
    chk("rdy1", 32'(rdy1), 32'(m_rdy(1)));
    chk("rdy2", 32'(rdy2), 32'(m_rdy(2)));
    seen_rdy1 = rdy1; seen_rdy2 = rdy2;
    @(posedge clk);
    model_edge();
    @(negedge clk);
    chk("gnt1", 32'(gnt1), 32'(m_phase == 1 && m_owner == 1));
    chk("gnt2", 32'(gnt2), 32'(m_phase == 1 && m_owner == 2));
    chk("sel", 32'(SEL), 32'(m_sel()));
    chk("dcp", DCP, m_dcp);
    chk("dcp_vld", 32'(dcp_vld), 32'(m_vld));
    chk("tmo", 32'(tmo), 32'(m_tmo));
  endtask

  task automatic do_reset();
    MRST = 1'b1;
    req1 = 0; req2 = 0; v1 = 0; v2 = 0; DB1 = '0; DB2 = '0; dcp_rdy = 0;
    model_reset();
    @(posedge clk);
    @(negedge clk);
    MRST = 1'b0;
  endtask

  // ---------------- directed table ----------------
  typedef struct {
    logic [3:0]  rv;    // {req1, req2, v1, v2}
    logic [31:0] d1, d2;
    logic        rd;
    logic [3:0]  rg;    // expected {rdy1, rdy2, gnt1, gnt2}
    logic [1:0]  sel;
    logic [31:0] dcp;
    logic        vld;
  } vec_t;

  function automatic vec_t mk(input logic [3:0] rv, input logic [31:0] d1, input logic [31:0] d2,
                              input logic rd, input logic [3:0] rg, input logic [1:0] sel,
                              input logic [31:0] dcp, input logic vld);
    vec_t t;
    t.rv = rv; t.d1 = d1; t.d2 = d2; t.rd = rd; t.rg = rg; t.sel = sel; t.dcp = dcp; t.vld = vld;
    return t;
  endfunction

  vec_t        tbl[14];
  int          hit, low_run;
  bit          prev_g;
  int          grants[$];
  logic        nr1, nr2;

  initial begin
    // bus 1 burst of four, then release
    tbl[0]  = mk(4'b1010, 32'hA0, 0, 1, 4'b0010, 2'b11, 32'h0,  0);
    tbl[1]  = mk(4'b1010, 32'hA0, 0, 1, 4'b1010, 2'b11, 32'hA0, 1);
    tbl[2]  = mk(4'b1010, 32'hA1, 0, 1, 4'b1010, 2'b11, 32'hA1, 1);
    tbl[3]  = mk(4'b1010, 32'hA2, 0, 1, 4'b1010, 2'b11, 32'hA2, 1);
    tbl[4]  = mk(4'b1010, 32'hA3, 0, 1, 4'b1000, 2'b01, 32'hA3, 1);
    tbl[5]  = mk(4'b0000, 0, 0,      1, 4'b0000, 2'b00, 32'hA3, 0);
    // bus 2 with consumer stall, then req2 dropped after two words
    tbl[6]  = mk(4'b0101, 0, 32'hB0, 0, 4'b0001, 2'b10, 32'hA3, 0);
    tbl[7]  = mk(4'b0101, 0, 32'hB0, 0, 4'b0101, 2'b10, 32'hB0, 1);
    tbl[8]  = mk(4'b0101, 0, 32'hB1, 0, 4'b0001, 2'b10, 32'hB0, 1);
    tbl[9]  = mk(4'b0101, 0, 32'hB1, 0, 4'b0001, 2'b10, 32'hB0, 1);
    tbl[10] = mk(4'b0101, 0, 32'hB1, 1, 4'b0101, 2'b10, 32'hB1, 1);
    tbl[11] = mk(4'b0001, 0, 32'hB2, 0, 4'b0000, 2'b01, 32'hB1, 1);
    tbl[12] = mk(4'b0001, 0, 32'hB3, 0, 4'b0000, 2'b00, 32'hB1, 1);
    tbl[13] = mk(4'b0000, 0, 0,      1, 4'b0000, 2'b00, 32'hB1, 0);

    do_reset();
    chk("rst_gnt1", 32'(gnt1), 0);
    chk("rst_gnt2", 32'(gnt2), 0);
    chk("rst_sel", 32'(SEL), 0);
    chk("rst_dcp", DCP, 0);
    chk("rst_vld", 32'(dcp_vld), 0);
    chk("rst_tmo", 32'(tmo), 0);

    for (int i = 0; i < 14; i++) begin
      step(tbl[i].rv[3], tbl[i].rv[2], tbl[i].rv[1], tbl[i].rv[0],
           tbl[i].d1, tbl[i].d2, tbl[i].rd);
      chk($sformatf("tbl%0d_rdy", i), 32'({seen_rdy1, seen_rdy2}), 32'(tbl[i].rg[3:2]));
      chk($sformatf("tbl%0d_gnt", i), 32'({gnt1, gnt2}), 32'(tbl[i].rg[1:0]));
      chk($sformatf("tbl%0d_sel", i), 32'(SEL), 32'(tbl[i].sel));
      chk($sformatf("tbl%0d_dcp", i), DCP, tbl[i].dcp);
      chk($sformatf("tbl%0d_vld", i), 32'(dcp_vld), 32'(tbl[i].vld));
    end

    // both requesters streaming from reset: alternating tenures, 2-cycle gaps
    do_reset();
    prev_g = 0; low_run = 0;
    for (int c = 0; c < 28; c++) begin
      step(1, 1, 1, 1, 32'h100 + c, 32'h200 + c, 1);
      if (gnt1 || gnt2) begin
        if (!prev_g) begin
          grants.push_back(gnt1 ? 1 : 2);
          if (grants.size() > 1) chk("gap_len", 32'(low_run), 32'd2);
        end
        low_run = 0;
      end else low_run++;
      prev_g = gnt1 || gnt2;
    end
    chk("grant_cnt", 32'(grants.size()), 32'd5);
    if (grants.size() >= 3) begin
      chk("grant_order0", 32'(grants[0]), 32'd1);
      chk("grant_order1", 32'(grants[1]), 32'd2);
      chk("grant_order2", 32'(grants[2]), 32'd1);
    end

    // owner that never sends a word
    do_reset();
    hit = 0;
    step(1, 0, 0, 0, 0, 0, 1);
    for (int k = 1; k <= 10; k++) begin
      if (hit == 0) begin
        step(1, 0, 0, 0, 0, 0, 1);
        if (tmo) hit = k;
      end
    end
`ifdef DAP_TIMEOUT_EN
    chk("tmo_cycle", 32'(hit), TMO);
    step(1, 1, 0, 0, 0, 0, 1);
    step(1, 1, 0, 0, 0, 0, 1);
    chk("tmo_ptr_gnt2", 32'(gnt2), 32'd1);
`else
    chk("no_tmo", 32'(hit), 32'd0);
    chk("hold_gnt1", 32'(gnt1), 32'd1);
`endif

    // asynchronous reset in the middle of a bus 2 burst (ptr = 1 then)
    do_reset();
    for (int c = 0; c < 9; c++) step(1, 1, 1, 1, 32'h300 + c, 32'h400 + c, 1);
    chk("pre_rst_gnt2", 32'(gnt2), 32'd1);
    chk("pre_rst_vld", 32'(dcp_vld), 32'd1);
    #2 MRST = 1'b1;
    model_reset();
    #1;
    chk("arst_gnt2", 32'(gnt2), 0);
    chk("arst_rdy2", 32'(rdy2), 0);
    chk("arst_sel", 32'(SEL), 0);
    chk("arst_dcp", DCP, 0);
    chk("arst_vld", 32'(dcp_vld), 0);
    @(negedge clk);
    MRST = 1'b0;
    step(1, 1, 1, 1, 32'h500, 32'h600, 1);
    chk("post_rst_gnt1", 32'(gnt1), 32'd1);

    // randomized traffic against the model
    do_reset();
    for (int c = 0; c < 800; c++) begin
      nr1 = req1; nr2 = req2;
      if ($urandom_range(7) == 0) nr1 = !nr1;
      if ($urandom_range(7) == 0) nr2 = !nr2;
      step(nr1, nr2, $urandom_range(3) != 0, $urandom_range(3) != 0,
           $urandom, $urandom, $urandom_range(2) != 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule
